pipe_stall_ctrl: RTL and testbench
==================================

PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 Parameter: CNT_W, default 16, width of stall_cnt.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 id_src1, id_src2  in  4 each  source register numbers of the instruction in ID.
REQ-005 id_uses_src2  in  1  ID instruction reads id_src2.
REQ-006 ex_memread, ex_dstreg  in  1, 4  EX instruction is a load; its destination register.
REQ-007 branch_taken  in  1  ID resolved a taken branch or jump this cycle.
REQ-008 hlt_id  in  1  HLT is decoded in ID.
REQ-009 imiss, ifill_done  in  1 each  I-cache miss level, held until fill; fill-complete pulse.
REQ-010 dmiss, dfill_done  in  1 each  D-cache miss level, held until fill; fill-complete pulse.
REQ-011 pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen  out  1 each  wen strobes to the PC and the four pipeline registers.
REQ-012 if_id_flush, id_ex_flush  out  1 each  load a NOP bubble into IF_ID / ID_EX this edge.
REQ-013 halted  out  1  pipeline drained after HLT.
REQ-014 stall_cnt  out  CNT_W  saturating count of fetch-stall cycles.

Function
REQ-015 FSM states: RUN, IMISS, DMISS, DRAIN, HALTED; outputs are combinational from state and current inputs.
REQ-016 Default (RUN, no event): all wen=1, all flush=0.
REQ-017 RUN event priority: dmiss > load-use > branch_taken > hlt_id > imiss; only the highest-priority event acts.
REQ-018 Load-use = ex_memread && ex_dstreg!=0 && (ex_dstreg==id_src1 || (id_uses_src2 && ex_dstreg==id_src2)); register 0 never hazards.
REQ-019 Freeze (dmiss in RUN, or any DMISS cycle): all five wen=0, both flush=0.
REQ-020 dmiss in RUN or IMISS -> DMISS next; DMISS -> RUN on the cycle after dfill_done; still frozen in the dfill_done cycle.
REQ-021 In DMISS, imiss/ifill_done/branch_taken/hlt_id are ignored.
REQ-022 Load-use: pc_wen=0, if_id_wen=0, id_ex_flush=1, id_ex_wen=1, ex_mem_wen=mem_wb_wen=1; exactly one bubble; state stays RUN.
REQ-023 branch_taken: pc_wen=1, if_id_flush=1, other wen=1; valid in RUN and IMISS; from IMISS returns to RUN (fill abandoned by cache).
REQ-024 imiss in RUN -> IMISS; RUN and IMISS with imiss: pc_wen=0, if_id_flush=1, downstream advances.
REQ-025 IMISS -> RUN the cycle after ifill_done; the ifill_done cycle still stalls fetch.
REQ-026 hlt_id (RUN or IMISS, no higher event): pc_wen=0, if_id_flush=1, -> DRAIN; 2-bit drain counter loaded with 3.
REQ-027 DRAIN: pc_wen=0, if_id_flush=1, downstream advances, counter decrements; at 0 -> HALTED; dmiss in DRAIN freezes without decrementing.
REQ-028 HALTED: all wen=0, flushes=0, halted=1; exits only via rst.
REQ-029 stall_cnt increments each cycle pc_wen==0 in RUN, IMISS or DMISS; saturates at all-ones; holds in DRAIN and HALTED.

Reset
REQ-030 rst at an edge: state=RUN, drain counter=0, stall_cnt=0, halted=0; overrides all inputs, including mid-DMISS or DRAIN.
REQ-031 Cycle after reset: all wen=1, flushes=0 unless inputs raise an event.

Structure
REQ-032 Package pipe_ctrl_pkg holds the state enum, REG_ZERO=4'h0 and DRAIN_CYCLES=3.
REQ-033 Load-use compare is a separate combinational sub-module, hazard_detect.

Verification
REQ-034 Load-use: ex_memread=1, ex_dstreg=3, id_src1=3 -> one cycle pc_wen=0, if_id_wen=0, id_ex_flush=1; ex_dstreg=0 -> no stall.
REQ-035 D-miss: dmiss high 5 cycles, dfill_done on 5th -> all wen=0 for 5 cycles, RUN on 6th; stall_cnt=5.
REQ-036 Collision: dmiss + load-use + branch_taken in the same cycle -> freeze only, no flush.
REQ-037 I-miss with branch: imiss 2 cycles, then branch_taken -> pc_wen=1, if_id_flush=1, state RUN.
REQ-038 Halt: hlt_id in RUN -> 3 DRAIN cycles, halted=1 on 4th and sticky; rst -> RUN, stall_cnt=0.
REQ-039 Saturation: CNT_W=4, 20 stalled cycles -> stall_cnt=15.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pipe_ctrl_pkg
// Shared types and constants for the pipeline stall/flush controller.
//   ctrlState_t : controller FSM states
//   ctrlOut_t   : bundle of the wen/flush/halted strobes driven each cycle
//   CTRL_*      : the fixed strobe patterns the controller can select from
// ---------------------------------------------------------------------------
package pipe_ctrl_pkg;

  typedef enum logic [2:0] {
    RUN,
    IMISS,
    DMISS,
    DRAIN,
    HALTED
  } ctrlState_t;

  // Register 0 is hard-wired to zero and can never carry a hazard.
  localparam logic [3:0] REG_ZERO     = 4'h0;
  // Cycles needed to let the instructions behind HLT leave the pipeline.
  localparam logic [1:0] DRAIN_CYCLES = 2'd3;

  typedef struct packed {
    logic pcWen;
    logic ifIdWen;
    logic idExWen;
    logic exMemWen;
    logic memWbWen;
    logic ifIdFlush;
    logic idExFlush;
    logic halted;
  } ctrlOut_t;

  // Everything advances, nothing squashed.
  localparam ctrlOut_t CTRL_FLOW = '{pcWen: 1'b1, ifIdWen: 1'b1, idExWen: 1'b1,
                                     exMemWen: 1'b1, memWbWen: 1'b1,
                                     ifIdFlush: 1'b0, idExFlush: 1'b0, halted: 1'b0};
  // Whole pipeline frozen in place (D-cache miss).
  localparam ctrlOut_t CTRL_FREEZE = '{pcWen: 1'b0, ifIdWen: 1'b0, idExWen: 1'b0,
                                       exMemWen: 1'b0, memWbWen: 1'b0,
                                       ifIdFlush: 1'b0, idExFlush: 1'b0, halted: 1'b0};
  // Hold PC and IF_ID, inject a bubble into EX (load-use).
  localparam ctrlOut_t CTRL_BUBBLE = '{pcWen: 1'b0, ifIdWen: 1'b0, idExWen: 1'b1,
                                       exMemWen: 1'b1, memWbWen: 1'b1,
                                       ifIdFlush: 1'b0, idExFlush: 1'b1, halted: 1'b0};
  // Take the new PC and squash the wrong-path fetch.
  localparam ctrlOut_t CTRL_REDIRECT = '{pcWen: 1'b1, ifIdWen: 1'b1, idExWen: 1'b1,
                                         exMemWen: 1'b1, memWbWen: 1'b1,
                                         ifIdFlush: 1'b1, idExFlush: 1'b0, halted: 1'b0};
  // Fetch stalled: PC held, NOPs fed into ID, downstream keeps moving.
  localparam ctrlOut_t CTRL_FETCH_STALL = '{pcWen: 1'b0, ifIdWen: 1'b1, idExWen: 1'b1,
                                            exMemWen: 1'b1, memWbWen: 1'b1,
                                            ifIdFlush: 1'b1, idExFlush: 1'b0, halted: 1'b0};
  // Pipeline empty and parked.
  localparam ctrlOut_t CTRL_HALT = '{pcWen: 1'b0, ifIdWen: 1'b0, idExWen: 1'b0,
                                     exMemWen: 1'b0, memWbWen: 1'b0,
                                     ifIdFlush: 1'b0, idExFlush: 1'b0, halted: 1'b1};

endpackage

// File: rtl/hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect
// Combinational load-use detector: flags when the load in EX writes a
// register that the instruction in ID reads.
//   exMemread  in  EX instruction is a load
//   exDstreg   in  4  destination of the EX load
//   idSrc1     in  4  first source of the ID instruction
//   idSrc2     in  4  second source of the ID instruction
//   idUsesSrc2 in  ID instruction actually reads idSrc2
//   loadUse    out hazard present this cycle
// ---------------------------------------------------------------------------
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       exMemread,
  input  logic [3:0] exDstreg,
  input  logic [3:0] idSrc1,
  input  logic [3:0] idSrc2,
  input  logic       idUsesSrc2,
  output logic       loadUse
);

  logic src1Match;
  logic src2Match;

  assign src1Match = (exDstreg == idSrc1);
  // src2 only matters when the ID instruction really reads it.
  assign src2Match = idUsesSrc2 && (exDstreg == idSrc2);
  assign loadUse   = exMemread && (exDstreg != REG_ZERO) && (src1Match || src2Match);

endmodule

// File: rtl/pipe_stall_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_stall_ctrl
// Central stall/flush controller for a 5-stage pipeline. Arbitrates D-cache
// misses, load-use hazards, taken branches, HLT and I-cache misses, and
// drives the write enables and bubble-inserts of the PC and pipeline regs.
//   clk, rst                       clock, synchronous active-high reset
//   id_src1/2, id_uses_src2        ID instruction source registers
//   ex_memread, ex_dstreg          EX load and its destination
//   branch_taken, hlt_id           ID redirect / halt decode
//   imiss/ifill_done               I-cache miss level / fill pulse
//   dmiss/dfill_done               D-cache miss level / fill pulse
//   pc_wen .. mem_wb_wen           register write enables
//   if_id_flush, id_ex_flush       load NOP bubble this edge
//   halted                         pipeline drained after HLT
//   stall_cnt                      saturating count of fetch-stall cycles
// Outputs are combinational from state and current inputs.
// ---------------------------------------------------------------------------
module pipe_stall_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       id_src1,
  input  logic [3:0]       id_src2,
  input  logic             id_uses_src2,
  input  logic             ex_memread,
  input  logic [3:0]       ex_dstreg,
  input  logic             branch_taken,
  input  logic             hlt_id,
  input  logic             imiss,
  input  logic             ifill_done,
  input  logic             dmiss,
  input  logic             dfill_done,
  output logic             pc_wen,
  output logic             if_id_wen,
  output logic             id_ex_wen,
  output logic             ex_mem_wen,
  output logic             mem_wb_wen,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  ctrlState_t       stateReg, stateNext;
  logic [1:0]       drainCntReg, drainCntNext;
  logic [CNT_W-1:0] stallCntReg;
  logic             loadUse;
  logic             countStall;
  ctrlOut_t         ctrl;

  hazard_detect uHazard (
    .exMemread (ex_memread),
    .exDstreg  (ex_dstreg),
    .idSrc1    (id_src1),
    .idSrc2    (id_src2),
    .idUsesSrc2(id_uses_src2),
    .loadUse   (loadUse)
  );

  // Next-state and strobe selection.
  always_comb begin
    stateNext    = stateReg;
    drainCntNext = drainCntReg;
    ctrl         = CTRL_FLOW;
    unique case (stateReg)
      RUN, IMISS: begin
        if (dmiss) begin
          ctrl      = CTRL_FREEZE;
          stateNext = DMISS;
        end else if (loadUse) begin
          ctrl = CTRL_BUBBLE;
          // A fill may still land while the bubble is being inserted.
          if (stateReg == IMISS && ifill_done) begin
            stateNext = RUN;
          end
        end else if (branch_taken) begin
          // From IMISS the cache drops the outstanding fill on redirect.
          ctrl      = CTRL_REDIRECT;
          stateNext = RUN;
        end else if (hlt_id) begin
          ctrl         = CTRL_FETCH_STALL;
          stateNext    = DRAIN;
          drainCntNext = DRAIN_CYCLES;
        end else if (stateReg == IMISS) begin
          // Fetch stays stalled through the fill-done cycle itself.
          ctrl = CTRL_FETCH_STALL;
          if (ifill_done) begin
            stateNext = RUN;
          end
        end else if (imiss) begin
          ctrl      = CTRL_FETCH_STALL;
          stateNext = IMISS;
        end
      end
      DMISS: begin
        // Frozen including the dfill_done cycle; all other events ignored.
        ctrl = CTRL_FREEZE;
        if (dfill_done) begin
          stateNext = RUN;
        end
      end
      DRAIN: begin
        if (dmiss) begin
          // Nothing moves, so the drain count must not move either.
          ctrl = CTRL_FREEZE;
        end else begin
          ctrl         = CTRL_FETCH_STALL;
          drainCntNext = drainCntReg - 2'd1;
          if (drainCntReg <= 2'd1) begin
            stateNext = HALTED;
          end
        end
      end
      HALTED: begin
        ctrl = CTRL_HALT;
      end
      default: begin
        ctrl      = CTRL_FREEZE;
        stateNext = RUN;
      end
    endcase
  end

  // Only stalls seen while the program is live are counted.
  assign countStall = !ctrl.pcWen &&
                      (stateReg == RUN || stateReg == IMISS || stateReg == DMISS);

  always_ff @(posedge clk) begin
    if (rst) begin
      stateReg    <= RUN;
      drainCntReg <= 2'd0;
      stallCntReg <= '0;
    end else begin
      stateReg    <= stateNext;
      drainCntReg <= drainCntNext;
      if (countStall && stallCntReg != CNT_MAX) begin
        stallCntReg <= stallCntReg + CNT_ONE;
      end
    end
  end

  assign pc_wen      = ctrl.pcWen;
  assign if_id_wen   = ctrl.ifIdWen;
  assign id_ex_wen   = ctrl.idExWen;
  assign ex_mem_wen  = ctrl.exMemWen;
  assign mem_wb_wen  = ctrl.memWbWen;
  assign if_id_flush = ctrl.ifIdFlush;
  assign id_ex_flush = ctrl.idExFlush;
  assign halted      = ctrl.halted;
  assign stall_cnt   = stallCntReg;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_stall_ctrl
// Scoreboard bench: the stimulus thread drives inputs, asks a behavioural
// model what the controller must present this cycle and queues it; a monitor
// on the falling edge pops and compares against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_pipe_stall_ctrl;

  localparam int CW      = 4;
  localparam int CNT_SAT = 15;

  // model modes
  localparam int M_RUN = 0, M_IMISS = 1, M_DMISS = 2, M_DRAIN = 3, M_HALTED = 4;
  // winning event of a cycle
  localparam int EV_NONE = 0, EV_FREEZE = 1, EV_BUBBLE = 2, EV_REDIRECT = 3,
                 EV_HLT = 4, EV_FETCH = 5, EV_DRAIN = 6, EV_HALT = 7;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] id_src1, id_src2, ex_dstreg;
  logic id_uses_src2, ex_memread, branch_taken, hlt_id;
  logic imiss, ifill_done, dmiss, dfill_done;
  logic pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen;
  logic if_id_flush, id_ex_flush, halted;
  logic [CW-1:0] stall_cnt;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src2(id_src2), .id_uses_src2(id_uses_src2),
    .ex_memread(ex_memread), .ex_dstreg(ex_dstreg),
    .branch_taken(branch_taken), .hlt_id(hlt_id),
    .imiss(imiss), .ifill_done(ifill_done),
    .dmiss(dmiss), .dfill_done(dfill_done),
    .pc_wen(pc_wen), .if_id_wen(if_id_wen), .id_ex_wen(id_ex_wen),
    .ex_mem_wen(ex_mem_wen), .mem_wb_wen(mem_wb_wen),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .halted(halted), .stall_cnt(stall_cnt)
  );

  typedef struct {
    int         cyc;
    logic [4:0] wen;    // {pc, if_id, id_ex, ex_mem, mem_wb}
    logic [1:0] flush;  // {if_id, id_ex}
    logic       halted;
    logic [3:0] cnt;
  } expect_t;

  expect_t sbq[$];
  expect_t monE;
  int checks = 0;
  int errors = 0;
  int cycNo  = 0;
  int mMode, mDrain, mCnt;

  task automatic check(input string name, input int cyc, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the oldest prediction.
  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      monE = sbq.pop_front();
      check("wen", monE.cyc, {27'd0, pc_wen, if_id_wen, id_ex_wen, ex_mem_wen, mem_wb_wen},
            {27'd0, monE.wen});
      check("flush", monE.cyc, {30'd0, if_id_flush, id_ex_flush}, {30'd0, monE.flush});
      check("halted", monE.cyc, {31'd0, halted}, {31'd0, monE.halted});
      check("stall_cnt", monE.cyc, {28'd0, stall_cnt}, {28'd0, monE.cnt});
    end
  end

  // Predict this cycle's outputs from the rules, queue them, update the model,
  // then move to just after the next rising edge.
  task automatic apply();
    expect_t e;
    int ev;
    bit lu;
    lu = ex_memread && (ex_dstreg != 4'd0) &&
         ((ex_dstreg == id_src1) || (id_uses_src2 && ex_dstreg == id_src2));

    if (mMode == M_HALTED)                    ev = EV_HALT;
    else if (mMode == M_DMISS || dmiss)       ev = EV_FREEZE;
    else if (mMode == M_DRAIN)                ev = EV_DRAIN;
    else if (lu)                              ev = EV_BUBBLE;
    else if (branch_taken)                    ev = EV_REDIRECT;
    else if (hlt_id)                          ev = EV_HLT;
    else if (mMode == M_IMISS || imiss)       ev = EV_FETCH;
    else                                      ev = EV_NONE;

    e.cyc    = cycNo;
    e.halted = 1'b0;
    e.cnt    = mCnt[3:0];
    case (ev)
      EV_HALT:     begin e.wen = 5'b00000; e.flush = 2'b00; e.halted = 1'b1; end
      EV_FREEZE:   begin e.wen = 5'b00000; e.flush = 2'b00; end
      EV_BUBBLE:   begin e.wen = 5'b00111; e.flush = 2'b01; end
      EV_REDIRECT: begin e.wen = 5'b11111; e.flush = 2'b10; end
      EV_HLT, EV_FETCH, EV_DRAIN:
                   begin e.wen = 5'b01111; e.flush = 2'b10; end
      default:     begin e.wen = 5'b11111; e.flush = 2'b00; end
    endcase
    sbq.push_back(e);

    if (e.wen[4] == 1'b0 && (mMode == M_RUN || mMode == M_IMISS || mMode == M_DMISS))
      mCnt = (mCnt < CNT_SAT) ? mCnt + 1 : CNT_SAT;

    case (ev)
      EV_FREEZE: begin
        if (mMode == M_DMISS)      mMode = dfill_done ? M_RUN : M_DMISS;
        else if (mMode != M_DRAIN) mMode = M_DMISS;
      end
      EV_BUBBLE:   if (mMode == M_IMISS && ifill_done) mMode = M_RUN;
      EV_REDIRECT: mMode = M_RUN;
      EV_HLT:      begin mMode = M_DRAIN; mDrain = 3; end
      EV_FETCH:    mMode = (mMode == M_IMISS && ifill_done) ? M_RUN : M_IMISS;
      EV_DRAIN:    begin mDrain--; if (mDrain == 0) mMode = M_HALTED; end
      default:     ;
    endcase

    if (rst) begin
      mMode  = M_RUN;
      mDrain = 0;
      mCnt   = 0;
    end

    cycNo++;
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    id_src1 = 4'd0; id_src2 = 4'd0; id_uses_src2 = 1'b0;
    ex_memread = 1'b0; ex_dstreg = 4'd0;
    branch_taken = 1'b0; hlt_id = 1'b0;
    imiss = 1'b0; ifill_done = 1'b0; dmiss = 1'b0; dfill_done = 1'b0;
  endtask

  task automatic resetCycle();
    rst = 1'b1;
    apply();
    rst = 1'b0;
  endtask

  initial begin
    int iLeft, dLeft;
    clearInputs();
    rst = 1'b1;
    @(posedge clk);
    #1;
    mMode = M_RUN; mDrain = 0; mCnt = 0;

    // reset state, then a quiet cycle
    apply();
    rst = 1'b0;
    apply();

    // load-use on src1, then a zero-register load that must not stall
    ex_memread = 1'b1; ex_dstreg = 4'd3; id_src1 = 4'd3;
    apply();
    clearInputs();
    apply();
    ex_memread = 1'b1; ex_dstreg = 4'd0; id_src1 = 4'd0;
    apply();
    ex_dstreg = 4'd5; id_src2 = 4'd5; id_uses_src2 = 1'b1;
    apply();
    id_uses_src2 = 1'b0;
    apply();
    clearInputs();

    // D-miss for 5 cycles, fill on the 5th
    resetCycle();
    for (int i = 0; i < 5; i++) begin
      dmiss = 1'b1;
      dfill_done = (i == 4);
      apply();
    end
    clearInputs();
    check("dmiss_stall_cnt", cycNo, {28'd0, stall_cnt}, 32'd5);
    apply();

    // dmiss + load-use + branch together: freeze only
    dmiss = 1'b1; branch_taken = 1'b1; ex_memread = 1'b1; ex_dstreg = 4'd7; id_src1 = 4'd7;
    apply();
    dfill_done = 1'b1;
    apply();
    clearInputs();
    apply();

    // I-miss for 2 cycles, then a taken branch redirects back to RUN
    imiss = 1'b1;
    apply();
    apply();
    branch_taken = 1'b1;
    apply();
    clearInputs();
    apply();

    // HLT: 3 drain cycles, halted sticky, reset recovers
    hlt_id = 1'b1;
    apply();
    clearInputs();
    for (int i = 0; i < 6; i++) apply();
    check("halted_sticky", cycNo, {31'd0, halted}, 32'd1);
    resetCycle();
    apply();

    // saturation with a 4-bit counter
    resetCycle();
    imiss = 1'b1;
    for (int i = 0; i < 20; i++) apply();
    ifill_done = 1'b1;
    apply();
    clearInputs();
    check("sat_stall_cnt", cycNo, {28'd0, stall_cnt}, 32'd15);
    apply();

    // randomized traffic with protocol-shaped miss windows
    iLeft = 0;
    dLeft = 0;
    for (int n = 0; n < 3000; n++) begin
      rst          = ($urandom_range(0, 39) == 0);
      id_src1      = 4'($urandom_range(0, 3));
      id_src2      = 4'($urandom_range(0, 3));
      id_uses_src2 = 1'($urandom_range(0, 1));
      ex_memread   = ($urandom_range(0, 2) == 0);
      ex_dstreg    = 4'($urandom_range(0, 3));
      branch_taken = ($urandom_range(0, 7) == 0);
      hlt_id       = ($urandom_range(0, 59) == 0);
      if (iLeft == 0 && $urandom_range(0, 11) == 0) iLeft = $urandom_range(1, 4);
      imiss      = (iLeft > 0);
      ifill_done = (iLeft == 1);
      if (iLeft > 0) iLeft--;
      if (dLeft == 0 && $urandom_range(0, 14) == 0) dLeft = $urandom_range(1, 5);
      dmiss      = (dLeft > 0);
      dfill_done = (dLeft == 1);
      if (dLeft > 0) dLeft--;
      apply();
    end
    rst = 1'b0;
    clearInputs();

    @(negedge clk);
    #1;
    check("scoreboard_drained", cycNo, sbq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
